// File: rtl/gshare_predictor.sv
// gshare_predictor: PHT of saturating counters indexed by PC or PC^GHR,
// plus a direct-mapped BTB, speculative GHR with mispredict repair.
module gshare_predictor #(
  parameter int ADDR_W  = 32,
  parameter int PHT_IDX = 7,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 7,
  parameter bit MODE    = 1'b1,
  parameter int BTB_IDX = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic              pre_taken,
  output logic [ADDR_W-1:0] pre_target,
  output logic              pre_hit,
  output logic [GHR_W-1:0]  pre_ghr_o,
  input  logic              spec_we_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [GHR_W-1:0]  wghr_i,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              mispredict_i
);

  localparam int PHT_N = 1 << PHT_IDX;
  localparam int BTB_N = 1 << BTB_IDX;
  localparam int TAG_W = ADDR_W - BTB_IDX - 2;

  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  pht     [PHT_N];
  logic              btb_v   [BTB_N];
  logic [TAG_W-1:0]  btb_tag [BTB_N];
  logic [ADDR_W-1:0] btb_tgt [BTB_N];
  logic [GHR_W-1:0]  ghr;

  logic [PHT_IDX-1:0] rhist, whist;
  logic [PHT_IDX-1:0] ridx, widx;
  logic [BTB_IDX-1:0] rbidx, wbidx;
  logic [TAG_W-1:0]   rtag, wtag;
  logic [CNT_W-1:0]   wcnt, wcnt_nxt;
  logic [GHR_W-1:0]   ghr_fix, ghr_spec;
  logic               upd, cnt_msb;
  logic               unused_bits;

  assign unused_bits = ^{raddr_i[1:0], waddr_i[1:0]};

  // Lookup and update index formation; history folds in only in gshare mode
  always_comb begin
    rhist = MODE ? PHT_IDX'(ghr)    : '0;
    whist = MODE ? PHT_IDX'(wghr_i) : '0;
    ridx  = raddr_i[PHT_IDX+1:2] ^ rhist;
    widx  = waddr_i[PHT_IDX+1:2] ^ whist;
    rbidx = raddr_i[BTB_IDX+1:2];
    wbidx = waddr_i[BTB_IDX+1:2];
    rtag  = raddr_i[ADDR_W-1:BTB_IDX+2];
    wtag  = waddr_i[ADDR_W-1:BTB_IDX+2];
  end

  // Combinational prediction from current (pre-edge) state
  always_comb begin
    cnt_msb    = pht[ridx][CNT_W-1];
    pre_hit    = btb_v[rbidx] && (btb_tag[rbidx] == rtag);
    pre_taken  = cnt_msb & pre_hit;
    pre_target = pre_hit ? btb_tgt[rbidx] : '0;
    pre_ghr_o  = ghr;
  end

  // Saturating counter next value and shifted history candidates
  always_comb begin
    upd      = we_i & rdy;
    wcnt     = pht[widx];
    wcnt_nxt = wcnt;
    if (res_taken && wcnt != CNT_MAX)
      wcnt_nxt = wcnt + 1'b1;
    else if (!res_taken && wcnt != '0)
      wcnt_nxt = wcnt - 1'b1;
    ghr_fix  = GHR_W'({wghr_i, res_taken});
    ghr_spec = GHR_W'({ghr, pre_taken});
  end

  // PHT counters, reset to weakly not-taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++)
        pht[i] <= CNT_INIT;
    end else if (upd) begin
      pht[widx] <= wcnt_nxt;
    end
  end

  // BTB valid bits; only taken branches allocate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++)
        btb_v[i] <= 1'b0;
    end else if (upd && res_taken) begin
      btb_v[wbidx] <= 1'b1;
    end
  end

  // BTB tag/target payload, gated by valid so no reset needed
  always_ff @(posedge clk) begin
    if (upd && res_taken && !rst) begin
      btb_tag[wbidx] <= wtag;
      btb_tgt[wbidx] <= res_target;
    end
  end

  // Global history: repair beats speculative shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ghr <= '0;
    else if (rdy) begin
      if (we_i && mispredict_i)
        ghr <= ghr_fix;
      else if (spec_we_i)
        ghr <= ghr_spec;
    end
  end

endmodule
